// File: rtl/sa_pkg.sv
// Shared types and byte-packing constants for the station-address writer.
package sa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    COMMIT,
    ERR
  } state_t;

  // Image geometry: six MAC bytes followed by a 16-bit checksum.
  localparam int SA_BYTES     = 8;
  localparam int SA_CSUM_W    = 16;
  localparam int SA_MAC_BYTES = 6;

  // Byte lanes holding the checksum; byte i lives at bits [8i+7:8i] of q.
  localparam int SA_CSUM_LO   = 6;
  localparam int SA_CSUM_HI   = 7;

endpackage

// File: rtl/sa_prom_writer_if.sv
// Byte-write handshake between the CSR write path and the station-address writer.
interface sa_prom_writer_if #(
  parameter int WIDTH = 8
);

  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             wr_last;

  modport master (output wr_valid, wr_data, wr_last, input wr_ready);
  modport slave  (input wr_valid, wr_data, wr_last, output wr_ready);

endinterface

// File: rtl/sa_checksum.sv
// Combinational 16-bit sum of the six MAC bytes, compared with the stored checksum.
module sa_checksum
  import sa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [SA_MAC_BYTES-1:0][WIDTH-1:0] mac,
  input  logic [SA_CSUM_W-1:0]               csum,
  output logic                               match
);

  logic [SA_CSUM_W-1:0] sum;

  // Accumulate the MAC bytes modulo 2^16 and compare against {b7,b6}.
  always_comb begin
    // NOTE: sum gets a value before the loop so no path leaves it unassigned (no latch).
    sum = '0;
    for (int i = 0; i < SA_MAC_BYTES; i++) begin
      // NOTE: blocking assignment here so each iteration sees the running total.
      sum = sum + SA_CSUM_W'(mac[i]);
    end
    match = (sum == csum);
  end

endmodule

// File: rtl/sa_prom_writer.sv
// Station-address writer: collects an 8-byte image over a valid/ready handshake,
// validates it, and commits it atomically to q.
// Build option: define SA_CHECKSUM_EN to reject images whose checksum bytes
// {b7,b6} differ from the 16-bit sum of b0..b5; otherwise only length is checked.
module sa_prom_writer
  import sa_pkg::*;
#(
  parameter int          ADDR_WIDTH = 3,
  parameter int          WIDTH      = 8,
  parameter logic [63:0] RESET_SA   = 64'h0000_0000_0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  sa_prom_writer_if.slave    wr,
  output logic [63:0]        q,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(SA_BYTES - 1);

  state_t                             state;
  logic [ADDR_WIDTH-1:0]              idx;
  logic [SA_BYTES-1:0][WIDTH-1:0]     shadow;
  logic                               csum_ok;
  logic                               xfer;

  assign xfer = wr.wr_valid && wr.wr_ready;

`ifdef SA_CHECKSUM_EN
  sa_checksum #(
    .WIDTH (WIDTH)
  ) u_checksum (
    .mac   (shadow[SA_MAC_BYTES-1:0]),
    .csum  ({shadow[SA_CSUM_HI], shadow[SA_CSUM_LO]}),
    .match (csum_ok)
  );
`else
  assign csum_ok = 1'b1;
`endif

  // Load/check/commit sequencer; all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      // NOTE: the shadow buffer is reset so a partial image can never leak into q.
      shadow      <= '0;
      q           <= RESET_SA;
      wr.wr_ready <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD;
            idx         <= '0;
            wr.wr_ready <= 1'b1;
            busy        <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state       <= IDLE;
            wr.wr_ready <= 1'b0;
            busy        <= 1'b0;
          end else if (xfer) begin
            shadow[idx] <= wr.wr_data;
            idx         <= idx + ADDR_WIDTH'(1);
            if (wr.wr_last || idx == LAST_IDX) begin
              // Exactly one legal exit: last byte flagged at the final index.
              state       <= (wr.wr_last && idx == LAST_IDX) ? CHECK : ERR;
              wr.wr_ready <= 1'b0;
            end
          end
        end
        CHECK: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= csum_ok ? COMMIT : ERR;
          end
        end
        COMMIT: begin
          q     <= shadow;
          done  <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end
        ERR: begin
          err   <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          wr.wr_ready <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_prom_writer.sv
// Self-checking bench for sa_prom_writer: a scoreboard queue holds the expected
// done/err events pushed by the driver; a negedge monitor pops and compares them.
module tb_sa_prom_writer;

  localparam logic [63:0] RESET_SA = 64'h0000_0000_00AA_0800;

  typedef logic [7:0] img_t [8];

  typedef struct {
    bit          is_err;
    logic [63:0] q;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [63:0] q;
  logic        busy;
  logic        done;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  logic [63:0] model_q = RESET_SA;
  exp_t        sb[$];
  exp_t        e;

  sa_prom_writer_if #(.WIDTH(8)) bus ();

  sa_prom_writer #(
    .ADDR_WIDTH (3),
    .WIDTH      (8),
    .RESET_SA   (RESET_SA)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .wr    (bus.slave),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input img_t img);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = img[i];
    return r;
  endfunction

  task automatic expect_done(input img_t img);
    exp_t x;
    model_q = pack(img);
    x.is_err = 1'b0;
    x.q      = model_q;
    x.lat    = 2;
    sb.push_back(x);
  endtask

  task automatic expect_err(input int lat);
    exp_t x;
    x.is_err = 1'b1;
    x.q      = model_q;
    x.lat    = lat;
    sb.push_back(x);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Offer n bytes; last_pos flags wr_last (-1 for none); optionally abort on the final one.
  task automatic send_img(input img_t img, input int n, input int last_pos, input bit abort_last);
    for (int i = 0; i < n; i++) begin
      int k;
      @(negedge clk);
      k = 0;
      while (!bus.wr_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (!bus.wr_ready) check("ready_timeout", 64'd0, 64'd1);
      bus.wr_valid = 1'b1;
      bus.wr_data  = img[i];
      bus.wr_last  = (i == last_pos);
      abort        = abort_last && (i == n - 1);
      @(posedge clk);
      #1;
      last_cyc     = cyc;
      bus.wr_valid = 1'b0;
      bus.wr_last  = 1'b0;
      abort        = 1'b0;
    end
  endtask

  task automatic settle(input string tag);
    repeat (4) @(negedge clk);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ready"}, 64'(bus.wr_ready), 64'd0);
    check({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
    check({tag, "_q"}, q, model_q);
  endtask

  // Scoreboard monitor: every done/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (done || err)) begin
      check("done_err_excl", 64'(done && err), 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_event", {63'd0, err}, {63'd0, done});
      end else begin
        e = sb.pop_front();
        check("event_kind", 64'(err), 64'(e.is_err));
        check("event_q", q, e.q);
        check("event_latency", 64'(cyc - last_cyc), 64'(e.lat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    img_t good, bad, good2, fresh, partial;
    good    = '{8'h08, 8'h00, 8'h2B, 8'h01, 8'h02, 8'h03, 8'h39, 8'h00};
    bad     = '{8'h08, 8'h00, 8'h2B, 8'h01, 8'h02, 8'h03, 8'h3A, 8'h00};
    good2   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h65, 8'h01};
    fresh   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'hFB, 8'h04};
    partial = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};

    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.wr_last  = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_q", q, RESET_SA);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(bus.wr_ready), 64'd0);
    check("rst_done_err", {62'd0, done, err}, 64'd0);
    rst = 1'b0;

    // Valid image commits two cycles after the last byte.
    do_start();
    check("load_busy", 64'(busy), 64'd1);
    expect_done(good);
    send_img(good, 8, 7, 1'b0);
    settle("good");
    check("good_q_const", q, 64'h0039_0302_012B_0008);

    // Checksum byte off by one.
    do_start();
`ifdef SA_CHECKSUM_EN
    expect_err(2);
`else
    expect_done(bad);
`endif
    send_img(bad, 8, 7, 1'b0);
    settle("bad_csum");

    // Short image: wr_last on the 5th byte.
    do_start();
    expect_err(1);
    send_img(good, 5, 4, 1'b0);
    settle("short");

    // Long image: no wr_last on the 8th byte.
    do_start();
    expect_err(1);
    send_img(good, 8, -1, 1'b0);
    settle("long");

    // Abort together with the 4th byte, then a full image from index 0.
    do_start();
    send_img(partial, 4, -1, 1'b1);
    settle("abort");
    do_start();
    expect_done(good2);
    send_img(good2, 8, 7, 1'b0);
    settle("after_abort");
    check("after_abort_q_const", q, 64'h0165_6655_4433_2211);

    // Reset in the middle of LOAD with a byte on offer.
    do_start();
    send_img(partial, 3, -1, 1'b0);
    @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h77;
    rst          = 1'b1;
    #1;
    check("midrst_ready", 64'(bus.wr_ready), 64'd0);
    check("midrst_q", q, RESET_SA);
    check("midrst_busy", 64'(busy), 64'd0);
    model_q = RESET_SA;
    @(negedge clk);
    rst          = 1'b0;
    bus.wr_valid = 1'b0;
    @(negedge clk);
    check("midrst_idle_ready", 64'(bus.wr_ready), 64'd0);
    do_start();
    expect_done(fresh);
    send_img(fresh, 8, 7, 1'b0);
    settle("fresh");
    check("fresh_q_const", q, 64'h04FB_FFEE_DDCC_BBAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_prom_writer.md
Name: sa_prom_writer

Overview:
Write-side companion to the station-address ROM. It accepts the 8-byte station-address image (6 MAC bytes plus a 2-byte checksum) one byte at a time over a valid/ready handshake. Bytes are assembled in a shadow buffer, checked, then committed atomically to a 64-bit output with the same packing as the ROM read side. It sits between the Q-bus CSR write path and the Ethernet MAC address consumers, so the station address can be reprogrammed at run time.

Parameters:
ADDR_WIDTH, 3, byte-index width; image depth = 2**ADDR_WIDTH (must be 8).
WIDTH, 8, byte width.
RESET_SA, 64'h0000_0000_0000_0000, value of q after reset; byte i = bits [8i+7:8i].

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active-high.
start  in  1  pulse that begins a load sequence.
abort  in  1  cancel the sequence in progress.
wr_valid  in  1  byte offered.
wr_ready  out  1  block accepts a byte this cycle.
wr_data  in  WIDTH  byte value.
wr_last  in  1  marks the final byte of the image.
q  out  64  committed image {b7,b6,b5,b4,b3,b2,b1,b0}.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when q is updated.
err  out  1  one-cycle pulse when a sequence is rejected.

Behaviour:
- Reset (async, rst=1): state=IDLE, byte index=0, shadow=0, q=RESET_SA, wr_ready=0, busy=0, done=0, err=0.
- A byte transfer occurs on a rising edge with wr_valid & wr_ready. wr_ready is registered and is 1 only in LOAD.
- State IDLE: start=1 → LOAD with index=0. All other inputs are ignored.
- State LOAD: each transfer writes shadow[index]=wr_data, then index+1.
  - wr_last on index 0..6 → ERR (short image).
  - index 7 without wr_last → ERR (long image).
  - index 7 with wr_last → CHECK.
  - abort → IDLE; no err, q unchanged. abort has priority over a simultaneous transfer.
  - start during LOAD is ignored.
- State CHECK (1 cycle):
  - Compute sum = b0+b1+b2+b3+b4+b5 mod 2^16 and compare it with {b7,b6}.
  - Match → COMMIT. Mismatch → ERR.
  - abort in CHECK → IDLE.
- State COMMIT (1 cycle): q<=shadow, done=1, then → IDLE.
- State ERR (1 cycle): err=1, q unchanged, then → IDLE.
- Latency: the last byte is accepted at edge N, CHECK runs in cycle N+1, and q/done are valid after edge N+2.
- The index never wraps; reaching 8 is impossible because index 7 always exits LOAD.
- Reset mid-sequence discards the shadow, restores RESET_SA on q, and returns to IDLE.
- done and err are never high together.

Optional Feature:
- Macro: SA_CHECKSUM_EN.
- Defined: the CHECK comparison is active as described above.
- Undefined: CHECK always proceeds to COMMIT; err fires only for short or long images.

Decomposition:
- Package sa_pkg holds:
  - the state enum {IDLE, LOAD, CHECK, COMMIT, ERR};
  - SA_BYTES=8 and SA_CSUM_W=16;
  - the byte-packing localparams.
- One sub-module is natural: sa_checksum, a combinational 6-byte 16-bit adder with a compare output, instantiated only under SA_CHECKSUM_EN.

Test Plan:
- Reset with RESET_SA=64'h0000_0000_00AA_0800 → q=64'h0000_0000_00AA_0800, busy=0, wr_ready=0.
- start, then bytes 08 00 2B 01 02 03 39 00 (last on 00) → done 2 cycles after the last byte, q=64'h0039_0302_012B_0008, err=0.
- Same sequence with byte6=3A → err pulse, no done, q unchanged; with SA_CHECKSUM_EN undefined → done and q=64'h003A_0302_012B_0008.
- wr_last on the 5th byte → err pulse, q unchanged, busy drops the next cycle; a 9-byte attempt (no wr_last on the 8th) → err after the 8th byte.
- abort after 4 bytes, then a full valid sequence → first attempt has no done/err; second commits correctly, proving index reset.
- Assert rst mid-LOAD with wr_valid held high → wr_ready=0 immediately, q=RESET_SA; start after release loads a fresh image from index 0.
